counter_rr_scheduler: RTL and testbench
=======================================

// Module: counter_rr_scheduler
// PURPOSE
//  Shares one WIDTH-bit incrementer between two requesters. Each requester owns a count register (q0, q1).
//  Grants go round-robin, at most one increment per clk0 cycle in total.
//  Sits in front of the dual 4-bit counter datapath. It replaces two free-running counters with one
//  arbitrated, clearable, enable-gated pair.
// PARAMETERS
//  WIDTH  4   count register width, in bits
//  MAX0   15  terminal value of q0; q0 wraps from MAX0 to 0 (MAX0 <= 2**WIDTH-1)
//  MAX1   15  terminal value of q1; q1 wraps from MAX1 to 0 (MAX1 <= 2**WIDTH-1)
// PORTS
//  clk0   in   1      sole clock; all state updates on its rising edge
//  rst    in   1      reset: synchronous, active-high
//  en     in   1      global enable; 0 suppresses all grants (clears still act)
//  req0   in   1      channel 0 increment request (level; one increment per granted cycle)
//  req1   in   1      channel 1 increment request
//  clr0   in   1      synchronous clear of q0
//  clr1   in   1      synchronous clear of q1
//  gnt0   out  1      combinational: channel 0 accepted this cycle
//  gnt1   out  1      combinational: channel 1 accepted this cycle
//  q0     out  WIDTH  channel 0 count (registered)
//  q1     out  WIDTH  channel 1 count (registered)
//  wrap0  out  1      registered 1-cycle pulse: q0 wrapped MAX0->0 on the previous edge
//  wrap1  out  1      registered 1-cycle pulse: q1 wrapped MAX1->0 on the previous edge
// BEHAVIOUR
//  Reset (rst=1 at an edge): q0=q1=0, wrap0=wrap1=0, last=1 (channel 0 wins first tie).
//   gnt0/gnt1 are forced 0 while rst=1.
//   Reset overrides clr/req and aborts any transfer in that cycle.
//  Eligibility: elig_x = req_x & ~clr_x & en & ~rst.
//  Arbitration (combinational, same cycle):
//   only elig0 -> gnt0=1; only elig1 -> gnt1=1; both -> grant the channel != last; none -> no grant.
//   gnt0 & gnt1 is never 1.
//  Handshake: valid/ready style. An increment occurs on the edge where req_x & gnt_x = 1.
//   A requester holding req high for N granted cycles gets exactly N increments.
//   No hold requirement: dropping req before grant withdraws the request.
//  Update on a granted edge for channel x:
//   q_x <= (q_x == MAXx) ? 0 : q_x + 1;
//   wrap_x <= (q_x == MAXx);
//   last <= x.
//  last changes only on a grant; idle cycles keep it.
//  clr_x=1: q_x <= 0 and wrap_x <= 0 at that edge. The other channel may still be granted that cycle.
//  wrap_x <= 0 on every edge without a wrapping increment of x (pulse width exactly 1 cycle).
//  Latency: q_x reflects a granted increment one cycle after the gnt cycle. No bypass.
//  Fairness: with both requesting continuously, grants alternate 0,1,0,1...
//   Worst-case wait for either channel is 1 cycle.
//  en=0: no grants; q and last hold unless cleared; wrap pulses still drop to 0.
//  Width rule: the increment is computed in WIDTH bits. MAXx = 2**WIDTH-1 gives natural rollover.
//   No value above MAXx is reachable from reset.
// TESTING
//  1 Reset: rst=1 for 2 cycles with req0=req1=1
//    -> gnt0=gnt1=0, q0=q1=0, wrap=0.
//    First cycle after release -> gnt0=1.
//  2 Contention: req0=req1=1 for 8 cycles from reset
//    -> grants 0,1,0,1,0,1,0,1; q0=4, q1=4.
//  3 Wrap: req0 held alone for 16 cycles (MAX0=15)
//    -> q0 goes 0..15 then 0; wrap0=1 for exactly the cycle after the 16th grant.
//  4 Clear vs request: q1=5, req1=clr1=1, req0=1 in one cycle
//    -> gnt1=0, gnt0=1; next cycle q1=0, q0 incremented.
//  5 Enable gating: en=0 for 3 cycles with both requests
//    -> no grants, q0/q1/last unchanged; en=1 resumes with the channel != last.
//  6 Mid-run reset: rst=1 while q0=9, q1=3 and both requesting
//    -> next cycle q0=q1=0, no grant that cycle, channel 0 wins first after release.

Source files
------------

// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit incrementer between two count registers.
// Each channel has its own clear and wrap pulse, and all updates are gated by a global enable.
module counter_rr_scheduler #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MAX0  = 15,
   parameter int unsigned MAX1  = 15
) (
   input  logic             clk0,
   input  logic             rst,
   input  logic             en,
   input  logic             req0,
   input  logic             req1,
   input  logic             clr0,
   input  logic             clr1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic             wrap0,
   output logic             wrap1
);

   localparam logic [WIDTH-1:0] TERM0 = WIDTH'(MAX0);
   localparam logic [WIDTH-1:0] TERM1 = WIDTH'(MAX1);

   logic elig0;
   logic elig1;
   logic last;   // channel granted most recently; the other channel wins a tie

   always_comb begin
      elig0 = req0 & ~clr0 & en & ~rst;
      elig1 = req1 & ~clr1 & en & ~rst;
      gnt0  = elig0 & (~elig1 | last);
      gnt1  = elig1 & (~elig0 | ~last);
   end

   always_ff @(posedge clk0) begin
      if (rst) begin
         q0    <= '0;
         q1    <= '0;
         wrap0 <= 1'b0;
         wrap1 <= 1'b0;
         last  <= 1'b1;
      end else begin
         wrap0 <= 1'b0;
         wrap1 <= 1'b0;
         if (clr0) begin
            q0 <= '0;
         end else if (gnt0) begin
            q0    <= (q0 == TERM0) ? '0 : q0 + WIDTH'(1);
            wrap0 <= (q0 == TERM0);
            last  <= 1'b0;
         end
         if (clr1) begin
            q1 <= '0;
         end else if (gnt1) begin
            q1    <= (q1 == TERM1) ? '0 : q1 + WIDTH'(1);
            wrap1 <= (q1 == TERM1);
            last  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Bench for counter_rr_scheduler: directed scenarios then random traffic,
// all checked against a behavioural model of the counting/arbitration rules.
module tb_counter_rr_scheduler;

   localparam int W  = 4;
   localparam int M0 = 15;
   localparam int M1 = 9;

   logic clk0 = 1'b0;
   logic rst, en, req0, req1, clr0, clr1;
   logic gnt0, gnt1, wrap0, wrap1;
   logic [W-1:0] q0, q1;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int mq0, mq1, mlast;
   bit mw0, mw1;
   logic sg0, sg1;

   counter_rr_scheduler #(.WIDTH(W), .MAX0(M0), .MAX1(M1)) dut (
      .clk0(clk0), .rst(rst), .en(en), .req0(req0), .req1(req1),
      .clr0(clr0), .clr1(clr1), .gnt0(gnt0), .gnt1(gnt1),
      .q0(q0), .q1(q1), .wrap0(wrap0), .wrap1(wrap1)
   );

   always #5 clk0 = ~clk0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check grants before the edge,
   // advance the model at the edge, check registered outputs after it.
   task automatic step(input bit r, input bit e, input bit a0, input bit a1,
                       input bit c0, input bit c1);
      bit el0, el1, g0, g1;
      @(negedge clk0);
      rst = r; en = e; req0 = a0; req1 = a1; clr0 = c0; clr1 = c1;
      #1;
      el0 = a0 && !c0 && e && !r;
      el1 = a1 && !c1 && e && !r;
      if (el0 && el1) begin
         g0 = (mlast != 0);
         g1 = (mlast == 0);
      end else begin
         g0 = el0;
         g1 = el1;
      end
      sg0 = gnt0;
      sg1 = gnt1;
      chk("gnt0", gnt0, g0);
      chk("gnt1", gnt1, g1);
      @(posedge clk0);
      if (r) begin
         mq0 = 0; mq1 = 0; mw0 = 0; mw1 = 0; mlast = 1;
      end else begin
         mw0 = 0; mw1 = 0;
         if (c0) mq0 = 0;
         else if (g0) begin mw0 = (mq0 == M0); mq0 = (mq0 + 1) % (M0 + 1); mlast = 0; end
         if (c1) mq1 = 0;
         else if (g1) begin mw1 = (mq1 == M1); mq1 = (mq1 + 1) % (M1 + 1); mlast = 1; end
      end
      #1;
      chk("q0", q0, mq0);
      chk("q1", q1, mq1);
      chk("wrap0", wrap0, mw0);
      chk("wrap1", wrap1, mw1);
   endtask

   initial begin
      mq0 = 0; mq1 = 0; mlast = 1; mw0 = 0; mw1 = 0;
      rst = 1; en = 1; req0 = 0; req1 = 0; clr0 = 0; clr1 = 0;

      // reset with both requesting, then contention from reset
      step(1, 1, 1, 1, 0, 0);
      step(1, 1, 1, 1, 0, 0);
      chk("rst_q0", q0, 0);
      chk("rst_q1", q1, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 1, 1, 0, 0);
         chk("cont_g0", sg0, (i % 2) == 0);
         chk("cont_g1", sg1, (i % 2) == 1);
      end
      chk("cont_q0", q0, 4);
      chk("cont_q1", q1, 4);

      // channel 0 alone wraps after 16 grants
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 1, 0, 0, 0);
         chk("wrap_pulse", wrap0, i == 15);
      end
      chk("wrap_q0", q0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("wrap_drop", wrap0, 0);

      // clear beats request, other channel still served
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 0);
      chk("pre_clr_q1", q1, 5);
      step(0, 1, 1, 1, 0, 1);
      chk("clr_g1", sg1, 0);
      chk("clr_g0", sg0, 1);
      chk("clr_q1", q1, 0);
      chk("clr_q0", q0, 1);

      // enable gating holds state, resumes with the other channel
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 0, 0);
         chk("en_nog", {sg0, sg1}, 0);
      end
      chk("en_q0", q0, 1);
      step(0, 1, 1, 1, 0, 0);
      chk("en_resume_g1", sg1, 1);

      // mid-run reset
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 0, 0);
      chk("mid_q0", q0, 9);
      chk("mid_q1", q1, 3);
      step(1, 1, 1, 1, 0, 0);
      chk("mid_nog", {sg0, sg1}, 0);
      chk("mid_q0_rst", q0, 0);
      step(0, 1, 1, 1, 0, 0);
      chk("mid_first_g0", sg0, 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
